set_cond_arbiter: RTL
=====================

# set_cond_arbiter

Round-robin arbiter and sequencer that shares a single combinational set-condition comparator among `NREQ` requesters. Each requester submits operands A and B plus a 3-bit condition code over a valid/ready handshake. The block grants one request at a time, drives the shared comparator, and captures its result. It returns the result with the requester ID over a valid/ready response channel. It sits between the issue logic of several datapath clients and the single set-condition unit.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: operand and result width.
- `IDW`, 2: requester-ID width, equal to ceil(log2 NREQ).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, packed the same way as `req_a`.
- `req_code`  in  NREQ*3  condition code; requester i uses bits [i*3 +: 3].
- `cmp_a`, `cmp_b`  out  WIDTH  operands driven to the shared comparator.
- `cmp_code`  out  3  code driven to the shared comparator.
- `cmp_c`  in  WIDTH  comparator result (16'b1 or 16'b0 when WIDTH=16).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_c`  out  WIDTH  captured comparison result.
- `rsp_err`  out  1  set when the code was illegal (110 or 111).
- `done_cnt`  out  16  count of completed responses; saturates at 16'hFFFF.

## Operation
- Code meanings: 000 is A<=B, 001 is A<B, 010 is A>=B, 011 is A>B, 100 is A==B, 101 is A!=B. All comparisons are unsigned. Codes 110 and 111 are illegal.
- The FSM has three states: IDLE, ISSUE, HOLD.
- IDLE:
  - Grant goes to the first requester i with `req_valid[i]=1`, searching from `ptr` upward and wrapping modulo NREQ.
  - `req_ready[i]` is asserted combinationally for that requester only.
  - On the handshake: latch a, b, code and id into the operand registers, set `ptr` to (i+1) mod NREQ, and go to ISSUE.
  - With no valid request, stay in IDLE and leave `ptr` unchanged.
- ISSUE:
  - `cmp_*` outputs present the latched operands; they are registered outputs.
  - At the clock edge, capture `rsp_c` as `cmp_c`, or as 0 with `rsp_err=1` when the code is illegal.
  - Go to HOLD.
- HOLD:
  - `rsp_valid=1`.
  - `rsp_id`, `rsp_c` and `rsp_err` stay stable until `rsp_valid & rsp_ready`.
  - On that handshake: increment `done_cnt` (saturating) and go to IDLE.
- `req_ready` is all zero in ISSUE and HOLD. There is only one outstanding operation.
- `cmp_a`, `cmp_b` and `cmp_code` hold the last latched values outside ISSUE.
- A requester that drops `req_valid` before its grant is simply skipped.
- Reset values: state IDLE, `ptr`=0, all `req_ready`=0, `cmp_a`/`cmp_b`=0, `cmp_code`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_c`=0, `rsp_err`=0, `done_cnt`=0.

## Timing
- Request handshake in cycle N: ISSUE is cycle N+1, and `rsp_valid` rises at the start of cycle N+2.
- Minimum period between successive accepts is 3 cycles. IDLE is entered after the response handshake, and a new accept is possible in that same IDLE cycle.
- `rsp_ready` may be held high in advance; the response is then consumed in cycle N+2.
- `rsp_ready` low stalls HOLD indefinitely. `req_ready` stays 0 and `ptr` does not move.
- Reset asserted in any state takes effect at the next edge:
  - the in-flight operation is discarded;
  - no response is produced;
  - `done_cnt` is cleared.
- The `ptr` wrap from NREQ-1 goes to 0.
- When requests arrive simultaneously, exactly one is granted, chosen by `ptr` order.

## Test plan
- **Single request.** Requester 2 sends A=5, B=9, code 001, with `rsp_ready=1`.
  - `req_ready`=4'b0100 in cycle 0.
  - `rsp_valid` in cycle 2 with `rsp_id`=2, `rsp_c`=1, `rsp_err`=0.
  - `done_cnt`=1.
- **Round-robin.** All four requesters hold valid continuously after reset.
  - Grant order is 0,1,2,3,0.
  - Accepts occur 3 cycles apart.
- **All codes.** Run A=B=16'h8000, then A=16'hFFFF with B=0, through codes 000..101.
  - Results are 1,0,1,0,1,0 for the first pair.
  - Results are 0,0,1,1,0,1 for the second pair.
- **Illegal code.** Requester 1 sends code 111.
  - `rsp_c`=0, `rsp_err`=1, `rsp_id`=1.
- **Backpressure.** Hold `rsp_ready` low for 5 cycles while requester 0 is also valid.
  - The response stays stable throughout.
  - `req_ready` stays 0.
  - Requester 0 is accepted in the cycle after the response handshake.
- **Reset mid-operation.** Assert `rst_n` low during ISSUE.
  - Next cycle: IDLE, all outputs at their reset values.
  - No response is produced and `ptr`=0.

Source files
------------

// File: rtl/set_cond_arbiter.sv
// Round-robin arbiter that shares one external set-condition comparator among NREQ
// requesters, returning each tagged result over a valid/ready response channel.
module set_cond_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*3-1:0]       req_code,
    output logic [WIDTH-1:0]        cmp_a,
    output logic [WIDTH-1:0]        cmp_b,
    output logic [2:0]              cmp_code,
    input  logic [WIDTH-1:0]        cmp_c,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_c,
    output logic                    rsp_err,
    output logic [15:0]             done_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [2:0]         opCode_q, opCode_d;
    logic [IDW-1:0]     opId_q, opId_d;
    logic [IDW-1:0]     rspId_q, rspId_d;
    logic [WIDTH-1:0]   rspC_q, rspC_d;
    logic               rspErr_q, rspErr_d;
    logic [15:0]        doneCnt_q, doneCnt_d;

    logic               grantValid;
    logic [IDW-1:0]     grantIdx;
    logic [IDW:0]       cand;

    // Search from ptr upward, wrapping; one extra bit keeps ptr+k from overflowing.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grantValid && req_valid[cand[IDW-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        opCode_d  = opCode_q;
        opId_d    = opId_q;
        rspId_d   = rspId_q;
        rspC_d    = rspC_q;
        rspErr_d  = rspErr_q;
        doneCnt_d = doneCnt_q;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    req_ready[grantIdx] = 1'b1;
                    opA_d    = req_a[grantIdx*WIDTH +: WIDTH];
                    opB_d    = req_b[grantIdx*WIDTH +: WIDTH];
                    opCode_d = req_code[grantIdx*3 +: 3];
                    opId_d   = grantIdx;
                    ptr_d    = (grantIdx == IDW'(NREQ-1)) ? '0 : grantIdx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                rspId_d = opId_q;
                // Codes 110 and 111 have no comparator meaning.
                if (opCode_q >= 3'b110) begin
                    rspC_d   = '0;
                    rspErr_d = 1'b1;
                end else begin
                    rspC_d   = cmp_c;
                    rspErr_d = 1'b0;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    if (doneCnt_q != 16'hFFFF) begin
                        doneCnt_d = doneCnt_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            opCode_q  <= '0;
            opId_q    <= '0;
            rspId_q   <= '0;
            rspC_q    <= '0;
            rspErr_q  <= 1'b0;
            doneCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            opCode_q  <= opCode_d;
            opId_q    <= opId_d;
            rspId_q   <= rspId_d;
            rspC_q    <= rspC_d;
            rspErr_q  <= rspErr_d;
            doneCnt_q <= doneCnt_d;
        end
    end

    assign cmp_a     = opA_q;
    assign cmp_b     = opB_q;
    assign cmp_code  = opCode_q;
    assign rsp_valid = (state_q == HOLD);
    assign rsp_id    = rspId_q;
    assign rsp_c     = rspC_q;
    assign rsp_err   = rspErr_q;
    assign done_cnt  = doneCnt_q;

endmodule
